// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage: word-addressed RAM plus a
// 32-byte I/O window (GPIO, cycle counter, compare timer, sticky status).
module dmem_responder #(
   parameter int          DEPTH   = 1024,
   parameter logic [31:0] IO_BASE = 32'h0000_8000,
   parameter int          GPIO_W  = 16
) (
   input  logic              CLOCK,
   input  logic              RST,
   input  logic              ena_rd,
   input  logic              ena_wr,
   input  logic [31:0]       alu_out_ext,
   input  logic [31:0]       dataram_wr,
   output logic [31:0]       dataram_rd,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq,
   output logic              fault
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;
   localparam logic [31:0] IO_END    = IO_BASE + 32'd32;

   localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
   localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
   localparam logic [2:0] OFF_CYCLE    = 3'd2;
   localparam logic [2:0] OFF_TCMP     = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;

   logic [31:0]       r_ram [DEPTH];
   logic [GPIO_W-1:0] r_gpio_out;
   logic [GPIO_W-1:0] r_sync1;
   logic [GPIO_W-1:0] r_sync2;
   logic [31:0]       r_cycle;
   logic [31:0]       r_timer_cmp;
   logic [1:0]        r_status;

   logic          w_misaligned;
   logic          w_ram_hit;
   logic          w_io_hit;
   logic          w_legal;
   logic          w_fault_ev;
   logic          w_ram_wr;
   logic          w_io_wr;
   logic          w_timer_hit;
   logic [AW-1:0] w_idx;
   logic [2:0]    w_off;
   logic [1:0]    w_w1c;
   logic [31:0]   w_rd;

   // Address decode and write qualification
   always_comb begin
      w_misaligned = (alu_out_ext[1:0] != 2'b00);
      w_ram_hit    = (alu_out_ext < RAM_BYTES);
      w_io_hit     = (alu_out_ext >= IO_BASE) && (alu_out_ext < IO_END);
      w_legal      = !w_misaligned && (w_ram_hit || w_io_hit);
      w_fault_ev   = (ena_rd || ena_wr) && !w_legal;
      w_ram_wr     = ena_wr && w_legal && w_ram_hit;
      w_io_wr      = ena_wr && w_legal && w_io_hit;
      w_idx        = alu_out_ext[AW+1:2];
      w_off        = alu_out_ext[4:2];
      w_timer_hit  = (r_cycle == r_timer_cmp);
      if (w_io_wr && (w_off == OFF_STATUS)) begin
         w_w1c = dataram_wr[1:0];
      end else begin
         w_w1c = 2'b00;
      end
   end

   // Load data mux; zero unless a legal read outside reset
   always_comb begin
      w_rd = 32'd0;
      if (RST || !ena_rd || !w_legal) begin
         w_rd = 32'd0;
      end else if (w_ram_hit) begin
         w_rd = r_ram[w_idx];
      end else begin
         case (w_off)
            OFF_GPIO_OUT: w_rd = 32'(r_gpio_out);
            OFF_GPIO_IN:  w_rd = 32'(r_sync2);
            OFF_CYCLE:    w_rd = r_cycle;
            OFF_TCMP:     w_rd = r_timer_cmp;
            OFF_STATUS:   w_rd = {30'd0, r_status};
            default:      w_rd = 32'd0;
         endcase
      end
   end

   assign dataram_rd = w_rd;

   // RAM is never reset; a store commits even in a reset cycle
   always_ff @(posedge CLOCK) begin
      if (w_ram_wr) begin
         r_ram[w_idx] <= dataram_wr;
      end
   end

   // I/O register file; STATUS bits set-dominant over write-1-to-clear
   always_ff @(posedge CLOCK) begin
      if (RST) begin
         r_gpio_out  <= '0;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_cycle     <= 32'd0;
         r_timer_cmp <= 32'hFFFF_FFFF;
         r_status    <= 2'b00;
      end else begin
         r_sync1  <= gpio_in;
         r_sync2  <= r_sync1;
         r_cycle  <= r_cycle + 32'd1;
         r_status <= (r_status & ~w_w1c) | {w_fault_ev, w_timer_hit};
         if (w_io_wr && (w_off == OFF_GPIO_OUT)) begin
            r_gpio_out <= dataram_wr[GPIO_W-1:0];
         end
         if (w_io_wr && (w_off == OFF_TCMP)) begin
            r_timer_cmp <= dataram_wr;
         end
      end
   end

   assign gpio_out = r_gpio_out;
   assign irq      = r_status[0];
   assign fault    = r_status[1];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

   localparam logic [31:0] IO = 32'h0000_8000;

   logic        CLOCK;
   logic        RST;
   logic        ena_rd;
   logic        ena_wr;
   logic [31:0] alu_out_ext;
   logic [31:0] dataram_wr;
   logic [31:0] dataram_rd;
   logic [15:0] gpio_in;
   logic [15:0] gpio_out;
   logic        irq;
   logic        fault;

   int checks = 0;
   int errors = 0;

   dmem_responder #(.DEPTH(1024), .IO_BASE(32'h0000_8000), .GPIO_W(16)) dut (
      .CLOCK(CLOCK), .RST(RST), .ena_rd(ena_rd), .ena_wr(ena_wr),
      .alu_out_ext(alu_out_ext), .dataram_wr(dataram_wr), .dataram_rd(dataram_rd),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq), .fault(fault)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic set_bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      ena_rd = rd; ena_wr = wr; alu_out_ext = a; dataram_wr = d;
      #1;
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      gpio_in = 16'h0000;
      set_bus(1'b0, 1'b0, 32'd0, 32'd0);
      tick(); tick();
      checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL rst_gpio_out got=%h exp=0000", gpio_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", fault); end
      set_bus(1'b1, 1'b0, IO + 32'd12, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL rst_rd_zero got=%h exp=00000000", dataram_rd); end
      RST = 1'b0;
      set_bus(1'b1, 1'b0, IO + 32'd8, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL rst_cycle0 got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (dataram_rd !== 32'd1) begin errors++; $display("FAIL rst_cycle1 got=%h exp=00000001", dataram_rd); end
      tick();
      checks++; if (dataram_rd !== 32'd2) begin errors++; $display("FAIL rst_cycle2 got=%h exp=00000002", dataram_rd); end
      set_bus(1'b1, 1'b0, IO + 32'd12, 32'd0);
      checks++; if (dataram_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_tcmp got=%h exp=ffffffff", dataram_rd); end
   endtask

   task automatic test_ram();
      set_bus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF); tick();
      set_bus(1'b0, 1'b1, 32'h14, 32'h0000_0000); tick();
      set_bus(1'b0, 1'b1, 32'hFFC, 32'h1357_9BDF); tick();
      set_bus(1'b1, 1'b0, 32'h10, 32'd0);
      checks++; if (dataram_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load got=%h exp=deadbeef", dataram_rd); end
      set_bus(1'b1, 1'b0, 32'h14, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL ram_load_zero got=%h exp=00000000", dataram_rd); end
      set_bus(1'b1, 1'b0, 32'hFFC, 32'd0);
      checks++; if (dataram_rd !== 32'h1357_9BDF) begin errors++; $display("FAIL ram_last_word got=%h exp=13579bdf", dataram_rd); end
      set_bus(1'b0, 1'b0, 32'h10, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL ram_no_rd got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ram_no_fault got=%b exp=0", fault); end
   endtask

   task automatic test_collision();
      set_bus(1'b0, 1'b1, 32'h20, 32'h1); tick();
      set_bus(1'b1, 1'b1, 32'h20, 32'h2);
      checks++; if (dataram_rd !== 32'h1) begin errors++; $display("FAIL coll_old got=%h exp=00000001", dataram_rd); end
      tick();
      set_bus(1'b1, 1'b0, 32'h20, 32'd0);
      checks++; if (dataram_rd !== 32'h2) begin errors++; $display("FAIL coll_new got=%h exp=00000002", dataram_rd); end
   endtask

   task automatic test_fault();
      set_bus(1'b0, 1'b1, 32'h0, 32'h77); tick();
      set_bus(1'b0, 1'b1, 32'h3, 32'h55); tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flt_misalign got=%b exp=1", fault); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flt_irq_quiet got=%b exp=0", irq); end
      set_bus(1'b1, 1'b0, 32'h0, 32'd0);
      checks++; if (dataram_rd !== 32'h77) begin errors++; $display("FAIL flt_no_write got=%h exp=00000077", dataram_rd); end
      set_bus(1'b0, 1'b1, IO + 32'd16, 32'h2); tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL flt_w1c got=%b exp=0", fault); end
      set_bus(1'b1, 1'b0, 32'h4000_0000, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL flt_unmapped_rd got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flt_unmapped got=%b exp=1", fault); end
      set_bus(1'b0, 1'b1, IO + 32'd16, 32'h2); tick();
      set_bus(1'b1, 1'b0, 32'h1000, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL flt_ram_end_rd got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flt_ram_end got=%b exp=1", fault); end
      set_bus(1'b0, 1'b1, IO + 32'd16, 32'h2); tick();
      set_bus(1'b0, 1'b1, IO + 32'd8, 32'd0); tick();
      set_bus(1'b0, 1'b1, IO + 32'd20, 32'hFFFF_FFFF); tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL flt_ro_writes got=%b exp=0", fault); end
      set_bus(1'b1, 1'b0, IO + 32'd20, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL flt_reserved_rd got=%h exp=00000000", dataram_rd); end
      set_bus(1'b1, 1'b0, IO + 32'd8, 32'd0);
      checks++; if (dataram_rd < 32'd10) begin errors++; $display("FAIL flt_cycle_wr_ignored got=%h exp>=0000000a", dataram_rd); end
   endtask

   task automatic test_gpio();
      set_bus(1'b0, 1'b1, IO, 32'hFFFF_A5A5); tick();
      checks++; if (gpio_out !== 16'hA5A5) begin errors++; $display("FAIL gpio_out got=%h exp=a5a5", gpio_out); end
      set_bus(1'b1, 1'b0, IO, 32'd0);
      checks++; if (dataram_rd !== 32'h0000_A5A5) begin errors++; $display("FAIL gpio_readback got=%h exp=0000a5a5", dataram_rd); end
      gpio_in = 16'h00FF;
      set_bus(1'b1, 1'b0, IO + 32'd4, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL gpio_in_c0 got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL gpio_in_c1 got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (dataram_rd !== 32'h0000_00FF) begin errors++; $display("FAIL gpio_in_c2 got=%h exp=000000ff", dataram_rd); end
   endtask

   task automatic test_timer();
      RST = 1'b1;
      set_bus(1'b0, 1'b0, 32'd0, 32'd0); tick();
      RST = 1'b0;
      set_bus(1'b0, 1'b1, IO + 32'd12, 32'd20); tick();
      for (int i = 0; i < 19; i++) begin
         set_bus(1'b1, 1'b0, IO + 32'd8, 32'd0);
         checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmr_early i=%0d got=%b exp=0", i, irq); end
         tick();
      end
      checks++; if (dataram_rd !== 32'd20) begin errors++; $display("FAIL tmr_cycle20 got=%h exp=00000014", dataram_rd); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_irq_rise got=%b exp=1", irq); end
      checks++; if (dataram_rd !== 32'd21) begin errors++; $display("FAIL tmr_cycle21 got=%h exp=00000015", dataram_rd); end
      set_bus(1'b0, 1'b1, IO + 32'd12, 32'd25); tick();
      set_bus(1'b0, 1'b0, 32'd0, 32'd0); tick(); tick();
      set_bus(1'b1, 1'b0, IO + 32'd8, 32'd0);
      checks++; if (dataram_rd !== 32'd24) begin errors++; $display("FAIL tmr_cycle24 got=%h exp=00000018", dataram_rd); end
      tick();
      set_bus(1'b0, 1'b1, IO + 32'd16, 32'h1); tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_set_wins got=%b exp=1", irq); end
      set_bus(1'b0, 1'b1, IO + 32'd16, 32'h1); tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmr_w1c got=%b exp=0", irq); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tmr_fault_quiet got=%b exp=0", fault); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      set_bus(1'b0, 1'b1, IO, 32'h1234); tick();
      set_bus(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D); tick();
      set_bus(1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 460; i++) tick();
      set_bus(1'b1, 1'b0, IO + 32'd8, 32'd0);
      v = dataram_rd;
      set_bus(1'b0, 1'b1, IO + 32'd12, v + 32'd2);
      tick(); tick();
      set_bus(1'b1, 1'b0, 32'h4000_0000, 32'd0); tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_pre_irq got=%b exp=1", irq); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mid_pre_fault got=%b exp=1", fault); end
      checks++; if (gpio_out !== 16'h1234) begin errors++; $display("FAIL mid_pre_gpio got=%h exp=1234", gpio_out); end
      RST = 1'b1;
      set_bus(1'b0, 1'b1, 32'h44, 32'h0000_1111); tick();
      set_bus(1'b1, 1'b1, IO, 32'h5555);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL mid_rd_in_rst got=%h exp=00000000", dataram_rd); end
      tick();
      RST = 1'b0;
      checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL mid_gpio got=%h exp=0000", gpio_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", irq); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault got=%b exp=0", fault); end
      set_bus(1'b1, 1'b0, IO + 32'd8, 32'd0);
      checks++; if (dataram_rd !== 32'd0) begin errors++; $display("FAIL mid_cycle0 got=%h exp=00000000", dataram_rd); end
      tick();
      checks++; if (dataram_rd !== 32'd1) begin errors++; $display("FAIL mid_cycle1 got=%h exp=00000001", dataram_rd); end
      set_bus(1'b1, 1'b0, IO + 32'd12, 32'd0);
      checks++; if (dataram_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_tcmp got=%h exp=ffffffff", dataram_rd); end
      set_bus(1'b1, 1'b0, 32'h40, 32'd0);
      checks++; if (dataram_rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL mid_ram_kept got=%h exp=cafef00d", dataram_rd); end
      set_bus(1'b1, 1'b0, 32'h44, 32'd0);
      checks++; if (dataram_rd !== 32'h0000_1111) begin errors++; $display("FAIL mid_ram_rst_store got=%h exp=00001111", dataram_rd); end
   endtask

   initial begin
      RST = 1'b1; ena_rd = 1'b0; ena_wr = 1'b0;
      alu_out_ext = 32'd0; dataram_wr = 32'd0; gpio_in = 16'h0000;
      test_reset();
      test_ram();
      test_collision();
      test_fault();
      test_gpio();
      test_timer();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
